// File: rtl/udma_lin_ch_mux_if.sv
// Beat-side (peripheral RX channels) and L2 write-side handshake bundle of the linear RX engine.
// master = engine; slave = peripherals plus L2 memory.
interface udma_lin_ch_mux_if #(
    parameter int N_CH   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
);
    logic [N_CH-1:0]        ch_valid_i;
    logic [N_CH*DATA_W-1:0] ch_data_i;
    logic [N_CH*2-1:0]      ch_datasize_i;
    logic [N_CH-1:0]        ch_ready_o;
    logic                   l2_req_o;
    logic                   l2_gnt_i;
    logic [ADDR_W-1:0]      l2_addr_o;
    logic [DATA_W-1:0]      l2_data_o;
    logic [1:0]             l2_datasize_o;
    logic [ID_W-1:0]        l2_id_o;

    modport master (
        input  ch_valid_i, ch_data_i, ch_datasize_i, l2_gnt_i,
        output ch_ready_o, l2_req_o, l2_addr_o, l2_data_o, l2_datasize_o, l2_id_o
    );

    modport slave (
        output ch_valid_i, ch_data_i, ch_datasize_i, l2_gnt_i,
        input  ch_ready_o, l2_req_o, l2_addr_o, l2_data_o, l2_datasize_o, l2_id_o
    );
endinterface

// File: rtl/udma_lin_ch_mux.sv
// N-channel linear RX address engine with one-deep shadow re-arm, round-robin onto one registered L2 write port.
// Latency 1 from beat acceptance to l2_req_o; beats are accepted only while the output register is empty or draining.
module udma_lin_ch_mux #(
    parameter int N_CH    = 4,
    parameter int ADDR_W  = 32,
    parameter int TRANS_W = 20,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [N_CH*ADDR_W-1:0]  cfg_startaddr_i,
    input  logic [N_CH*TRANS_W-1:0] cfg_size_i,
    input  logic [N_CH-1:0]         cfg_continuous_i,
    input  logic [N_CH-1:0]         cfg_en_i,
    input  logic [N_CH-1:0]         cfg_clr_i,
    output logic [N_CH-1:0]         en_o,
    output logic [N_CH-1:0]         pending_o,
    output logic [N_CH*ADDR_W-1:0]  curr_addr_o,
    output logic [N_CH*TRANS_W-1:0] bytes_left_o,
    output logic [N_CH-1:0]         events_o,
    udma_lin_ch_mux_if.master       dma
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        size;
        logic [ID_W-1:0]   id;
    } l2_beat_t;

    logic [ADDR_W-1:0] curr_addr [N_CH];
    logic [N_CH-1:0]   cand;
    logic [N_CH-1:0]   grant;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   rr_ptr;
    logic              gnt_any;
    logic              out_free;
    logic              req_q;
    l2_beat_t          out_q;

    always_comb begin
        int idx;
        idx      = 0;
        out_free = !req_q || dma.l2_gnt_i;
        cand     = dma.ch_valid_i & en_o & ~cfg_clr_i;
        grant    = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        if (out_free) begin
            for (int k = 0; k < N_CH; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!gnt_any && cand[idx]) begin
                    gnt_any    = 1'b1;
                    gnt_idx    = ID_W'(idx);
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            req_q  <= 1'b0;
            out_q  <= '0;
            rr_ptr <= '0;
        end else if (gnt_any) begin
            req_q      <= 1'b1;
            out_q.addr <= curr_addr[gnt_idx];
            out_q.data <= dma.ch_data_i[gnt_idx*DATA_W +: DATA_W];
            // 2'b11 is carried downstream as a word beat
            out_q.size <= (dma.ch_datasize_i[gnt_idx*2 +: 2] == 2'b11) ? 2'b10
                                                                       : dma.ch_datasize_i[gnt_idx*2 +: 2];
            out_q.id   <= gnt_idx;
            rr_ptr     <= (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
        end else if (dma.l2_gnt_i) begin
            req_q <= 1'b0;
        end
    end

    assign dma.ch_ready_o    = grant;
    assign dma.l2_req_o      = req_q;
    assign dma.l2_addr_o     = out_q.addr;
    assign dma.l2_data_o     = out_q.data;
    assign dma.l2_datasize_o = out_q.size;
    assign dma.l2_id_o       = out_q.id;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [ADDR_W-1:0]  cfg_addr;
        logic [ADDR_W-1:0]  addr_q;
        logic [ADDR_W-1:0]  sh_addr;
        logic [TRANS_W-1:0] cfg_size;
        logic [TRANS_W-1:0] left_q;
        logic [TRANS_W-1:0] sh_size;
        logic [2:0]         bs;
        logic               active_q, pend_q, cont_q, sh_cont, evt_q;
        logic               load_req, last;

        assign cfg_addr = cfg_startaddr_i[g*ADDR_W +: ADDR_W];
        assign cfg_size = cfg_size_i[g*TRANS_W +: TRANS_W];
        assign bs       = (dma.ch_datasize_i[g*2 +: 2] == 2'b00) ? 3'd1 :
                          (dma.ch_datasize_i[g*2 +: 2] == 2'b01) ? 3'd2 : 3'd4;
        assign load_req = cfg_en_i[g] && (cfg_size != '0);
        assign last     = grant[g] && (left_q <= TRANS_W'(bs));

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                active_q <= 1'b0;
                pend_q   <= 1'b0;
                cont_q   <= 1'b0;
                evt_q    <= 1'b0;
                addr_q   <= '0;
                left_q   <= '0;
                sh_addr  <= '0;
                sh_size  <= '0;
                sh_cont  <= 1'b0;
            end else begin
                evt_q <= last;
                if (cfg_clr_i[g]) begin
                    active_q <= 1'b0;
                    pend_q   <= 1'b0;
                    left_q   <= '0;
                end else if (!active_q) begin
                    if (load_req) begin
                        active_q <= 1'b1;
                        addr_q   <= cfg_addr;
                        left_q   <= cfg_size;
                        cont_q   <= cfg_continuous_i[g];
                    end
                end else if (last) begin
                    // Reload order: queued shadow, then a config arriving this cycle, then auto-reload.
                    if (pend_q) begin
                        addr_q <= sh_addr;
                        left_q <= sh_size;
                        cont_q <= sh_cont;
                        pend_q <= load_req;
                    end else if (load_req) begin
                        addr_q <= cfg_addr;
                        left_q <= cfg_size;
                        cont_q <= cfg_continuous_i[g];
                    end else if (cont_q) begin
                        addr_q <= cfg_addr;
                        left_q <= cfg_size;
                    end else begin
                        active_q <= 1'b0;
                        addr_q   <= addr_q + ADDR_W'(bs);
                        left_q   <= '0;
                    end
                    if (load_req) begin
                        sh_addr <= cfg_addr;
                        sh_size <= cfg_size;
                        sh_cont <= cfg_continuous_i[g];
                    end
                end else begin
                    if (grant[g]) begin
                        addr_q <= addr_q + ADDR_W'(bs);
                        left_q <= left_q - TRANS_W'(bs);
                    end
                    if (load_req) begin
                        sh_addr <= cfg_addr;
                        sh_size <= cfg_size;
                        sh_cont <= cfg_continuous_i[g];
                        pend_q  <= 1'b1;
                    end
                end
            end
        end

        assign curr_addr[g]                      = addr_q;
        assign en_o[g]                           = active_q;
        assign pending_o[g]                      = pend_q;
        assign events_o[g]                       = evt_q;
        assign curr_addr_o[g*ADDR_W +: ADDR_W]   = addr_q;
        assign bytes_left_o[g*TRANS_W +: TRANS_W] = left_q;
    end
endmodule

// File: tb/tb_udma_lin_ch_mux.sv
// Randomised and directed bench: a transfer-descriptor reference model predicts L2 writes into a scoreboard
// queue; an independent monitor pops and compares on every l2_req_o & l2_gnt_i.
`timescale 1ns/1ps
module tb_udma_lin_ch_mux;
    localparam int N = 4, AW = 32, TW = 20, DW = 32, IW = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [N*AW-1:0] cfg_startaddr;
    logic [N*TW-1:0] cfg_size;
    logic [N-1:0]    cfg_cont, cfg_en, cfg_clr;
    logic [N-1:0]    en, pending, events;
    logic [N*AW-1:0] curr_addr;
    logic [N*TW-1:0] bytes_left;

    udma_lin_ch_mux_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dma ();

    udma_lin_ch_mux #(.N_CH(N), .ADDR_W(AW), .TRANS_W(TW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .cfg_startaddr_i(cfg_startaddr), .cfg_size_i(cfg_size), .cfg_continuous_i(cfg_cont),
        .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
        .en_o(en), .pending_o(pending), .curr_addr_o(curr_addr), .bytes_left_o(bytes_left),
        .events_o(events), .dma(dma)
    );

    int checks = 0;
    int failures = 0;

    typedef logic [67:0] wr_t;
    typedef struct packed { logic [31:0] addr; logic [19:0] left; logic cont; } desc_t;

    wr_t         exp_q[$];
    logic [31:0] seen_addr[$];
    int          seen_id[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each channel owns a current descriptor and an optional queued one.
    desc_t       cur[N], shd[N];
    logic        busy[N], queued[N];
    logic [N-1:0] m_evt;
    int          m_rr;
    logic        m_req;

    function automatic desc_t from_cfg(input int i);
        return {cfg_startaddr[i*AW +: AW], cfg_size[i*TW +: TW], cfg_cont[i]};
    endfunction

    always @(negedge clk) begin : model
        logic [N-1:0]    act_v, pend_v, rdy_v, nxt_evt;
        logic [N*AW-1:0] addr_v;
        logic [N*TW-1:0] left_v;
        logic [1:0]      ds;
        int              bs, g, idx;
        logic            newok;
        if (!rstn) begin
            m_req = 1'b0; m_rr = 0; m_evt = '0;
            for (int i = 0; i < N; i++) begin
                busy[i] = 1'b0; queued[i] = 1'b0; cur[i] = '0; shd[i] = '0;
            end
            exp_q.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                act_v[i] = busy[i]; pend_v[i] = queued[i];
                addr_v[i*AW +: AW] = cur[i].addr; left_v[i*TW +: TW] = cur[i].left;
            end
            chk("en_o", en, act_v);
            chk("pending_o", pending, pend_v);
            chk("curr_addr_o", curr_addr, addr_v);
            chk("bytes_left_o", bytes_left, left_v);
            chk("events_o", events, m_evt);
            g = -1;
            if (!m_req || dma.l2_gnt_i)
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && dma.ch_valid_i[idx] && busy[idx] && !cfg_clr[idx]) g = idx;
                end
            rdy_v = '0;
            if (g >= 0) rdy_v[g] = 1'b1;
            chk("ch_ready_o", dma.ch_ready_o, rdy_v);
            if (g >= 0) begin
                ds = dma.ch_datasize_i[g*2 +: 2];
                exp_q.push_back({cur[g].addr, dma.ch_data_i[g*DW +: DW], (ds == 2'd3) ? 2'd2 : ds, IW'(g)});
                m_rr = (g + 1) % N;
                m_req = 1'b1;
            end else if (dma.l2_gnt_i) m_req = 1'b0;
            nxt_evt = '0;
            for (int i = 0; i < N; i++) begin
                ds = dma.ch_datasize_i[i*2 +: 2];
                bs = (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
                newok = cfg_en[i] && (cfg_size[i*TW +: TW] != 0);
                if (cfg_clr[i]) begin
                    busy[i] = 1'b0; queued[i] = 1'b0; cur[i].left = '0;
                end else if (!busy[i]) begin
                    if (newok) begin busy[i] = 1'b1; cur[i] = from_cfg(i); end
                end else if (g == i && int'(cur[i].left) <= bs) begin
                    nxt_evt[i] = 1'b1;
                    if (queued[i]) begin cur[i] = shd[i]; queued[i] = newok; end
                    else if (newok) cur[i] = from_cfg(i);
                    else if (cur[i].cont) begin cur[i].addr = from_cfg(i).addr; cur[i].left = from_cfg(i).left; end
                    else begin busy[i] = 1'b0; cur[i].addr = cur[i].addr + 32'(bs); cur[i].left = '0; end
                    if (newok) shd[i] = from_cfg(i);
                end else begin
                    if (g == i) begin cur[i].addr = cur[i].addr + 32'(bs); cur[i].left = cur[i].left - 20'(bs); end
                    if (newok) begin shd[i] = from_cfg(i); queued[i] = 1'b1; end
                end
            end
            m_evt = nxt_evt;
        end
    end

    logic hold_vld;
    wr_t  hold_dat, got;
    always @(negedge clk) begin : monitor
        got = {dma.l2_addr_o, dma.l2_data_o, dma.l2_datasize_o, dma.l2_id_o};
        if (!rstn) hold_vld = 1'b0;
        else begin
            if (hold_vld) chk("l2_hold_stable", got, hold_dat);
            if (dma.l2_req_o && dma.l2_gnt_i) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL l2_write: got %0h with no write expected at %0t", got, $time);
                end else chk("l2_write", got, exp_q.pop_front());
                seen_addr.push_back(dma.l2_addr_o);
                seen_id.push_back(int'(dma.l2_id_o));
            end
            hold_vld = dma.l2_req_o && !dma.l2_gnt_i;
            hold_dat = got;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        dma.ch_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic arm(input int ch, input logic [31:0] a, input logic [19:0] s, input logic c);
        cfg_startaddr[ch*AW +: AW] = a;
        cfg_size[ch*TW +: TW] = s;
        cfg_cont[ch] = c;
        cfg_en[ch] = 1'b1;
        cyc();
        cfg_en[ch] = 1'b0;
    endtask

    task automatic drain();
        dma.ch_valid_i = '0;
        dma.l2_gnt_i = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
        cyc();
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rstn = 1'b0;
        cfg_startaddr = '0; cfg_size = '0; cfg_cont = '0; cfg_en = '0; cfg_clr = '0;
        dma.ch_valid_i = '0; dma.ch_data_i = '0; dma.ch_datasize_i = '0; dma.l2_gnt_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        cyc();
        chk("reset_l2_req", dma.l2_req_o, 0);
        chk("reset_en", en, 0);

        // Round-robin with all channels requesting, then a 3-cycle stall.
        seen_addr.delete(); seen_id.delete();
        dma.ch_datasize_i = 8'hAA;
        for (int i = 0; i < N; i++) begin
            cfg_startaddr[i*AW +: AW] = 32'h4000 + 32'(i) * 32'h100;
            cfg_size[i*TW +: TW] = 20'h100;
        end
        cfg_en = '1; cyc(); cfg_en = '0;
        dma.ch_valid_i = '1; dma.l2_gnt_i = 1'b1;
        repeat (6) cyc();
        dma.l2_gnt_i = 1'b0;
        repeat (3) cyc();
        dma.l2_gnt_i = 1'b1;
        repeat (2) cyc();
        cfg_clr = '1; cyc(); cfg_clr = '0;
        drain();
        if (seen_id.size() >= 5)
            for (int k = 0; k < 5; k++) chk("rr_order", seen_id[k], k % N);
        else chk("rr_count", seen_id.size(), 5);

        // Single transfer, two word beats.
        seen_addr.delete();
        dma.ch_datasize_i[1:0] = 2'd2;
        arm(0, 32'h1000, 20'd8, 1'b0);
        dma.ch_valid_i[0] = 1'b1;
        repeat (4) cyc();
        drain();
        chk("single_count", seen_addr.size(), 2);
        if (seen_addr.size() >= 2) begin
            chk("single_addr0", seen_addr[0], 32'h1000);
            chk("single_addr1", seen_addr[1], 32'h1004);
        end
        chk("single_en_off", en[0], 0);
        chk("single_left", bytes_left[TW-1:0], 0);

        // Pending re-arm on ch1 with half-word beats.
        seen_addr.delete();
        dma.ch_datasize_i[3:2] = 2'd1;
        arm(1, 32'h1800, 20'd4, 1'b0);
        arm(1, 32'h2000, 20'd4, 1'b0);
        chk("pending_set", pending[1], 1);
        dma.ch_valid_i[1] = 1'b1;
        repeat (6) cyc();
        drain();
        if (seen_addr.size() == 4) begin
            chk("rearm_addr1", seen_addr[1], 32'h1802);
            chk("rearm_addr2", seen_addr[2], 32'h2000);
            chk("rearm_addr3", seen_addr[3], 32'h2002);
        end else chk("rearm_count", seen_addr.size(), 4);

        // Continuous byte transfer on ch2.
        seen_addr.delete();
        dma.ch_datasize_i[5:4] = 2'd0;
        arm(2, 32'h300, 20'd2, 1'b1);
        dma.ch_valid_i[2] = 1'b1;
        repeat (4) cyc();
        chk("cont_en_held", en[2], 1);
        cfg_clr[2] = 1'b1; cyc(); cfg_clr[2] = 1'b0;
        drain();
        if (seen_addr.size() == 4) begin
            chk("cont_addr2", seen_addr[2], 32'h300);
            chk("cont_addr3", seen_addr[3], 32'h301);
        end else chk("cont_count", seen_addr.size(), 4);

        // Clear with one beat parked in the output register.
        seen_addr.delete();
        dma.ch_datasize_i[7:6] = 2'd2;
        dma.l2_gnt_i = 1'b0;
        arm(3, 32'h5000, 20'h40, 1'b0);
        dma.ch_valid_i[3] = 1'b1;
        repeat (2) cyc();
        cfg_clr[3] = 1'b1; cyc(); cfg_clr[3] = 1'b0;
        dma.ch_valid_i = '0;
        chk("clr_en_off", en[3], 0);
        drain();
        chk("clr_inflight_count", seen_addr.size(), 1);

        // Zero-size arm is ignored; address wraps past 2^32.
        arm(0, 32'h10, 20'd0, 1'b0);
        chk("size0_ignored", en[0], 0);
        seen_addr.delete();
        arm(0, 32'hFFFF_FFFC, 20'd8, 1'b0);
        dma.ch_valid_i[0] = 1'b1;
        repeat (3) cyc();
        drain();
        if (seen_addr.size() == 2) chk("wrap_addr", seen_addr[1], 32'h0);
        else chk("wrap_count", seen_addr.size(), 2);

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            dma.ch_valid_i = 4'($urandom());
            dma.ch_datasize_i = 8'($urandom());
            dma.l2_gnt_i = ($urandom_range(3) != 0);
            cfg_en = '0; cfg_clr = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) begin
                    cfg_startaddr[i*AW +: AW] = ($urandom_range(1) != 0) ? $urandom() : 32'hFFFF_FFF8;
                    cfg_size[i*TW +: TW] = 20'($urandom_range(12));
                    cfg_cont[i] = 1'($urandom_range(1));
                    cfg_en[i] = 1'b1;
                end
                if ($urandom_range(59) == 0) cfg_clr[i] = 1'b1;
            end
            cyc();
        end
        cfg_en = '0;
        cfg_clr = '1; cyc(); cfg_clr = '0;
        drain();

        // Asynchronous reset while a request is held.
        dma.l2_gnt_i = 1'b0;
        arm(0, 32'h7000, 20'h40, 1'b0);
        dma.ch_valid_i[0] = 1'b1;
        repeat (2) cyc();
        chk("pre_reset_req", dma.l2_req_o, 1);
        rstn = 1'b0;
        #1;
        chk("async_reset_req", dma.l2_req_o, 0);
        chk("async_reset_en", en, 0);
        chk("async_reset_addr", curr_addr, 0);
        chk("async_reset_left", bytes_left, 0);
        dma.ch_valid_i = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        cyc();
        chk("post_reset_pending", pending, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
